// File: rtl/display_scan_sequencer.sv
// 8-digit 7-segment scan sequencer: digit select, active-low anodes,
// anti-ghost blanking, brightness, enable mask and leading-zero blanking.
module display_scan_sequencer #(
  parameter int SUB_CYCLES = 6250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [3:0]  brightness,
  input  logic [7:0]  digit_en,
  input  logic        lzb_en,
  output logic [2:0]  select,
  output logic [7:0]  anodes,
  output logic        frame_tick
);

  localparam int CW = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SUB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    slot_q, slot_d;

  logic [3:0]    sh_bright_q, sh_bright_d;
  logic [7:0]    sh_en_q, sh_en_d;
  logic          sh_lzb_q, sh_lzb_d;
  logic [31:0]   sh_dig_q, sh_dig_d;

  logic [2:0]    select_q, select_d;
  logic [7:0]    anodes_q, anodes_d;
  logic          tick_q, tick_d;

  logic          cnt_end, sub_end, frame_end, load, lit;
  logic [7:0]    zero_from, blank;

  always_comb begin
    cnt_end   = (cnt_q == CNT_MAX);
    sub_end   = cnt_end && (sub_q == 4'hF);
    frame_end = sub_end && (slot_q == 3'd7);

    cnt_d  = cnt_end ? '0 : cnt_q + 1'b1;
    sub_d  = cnt_end ? sub_q + 4'd1 : sub_q;
    slot_d = sub_end ? slot_q + 3'd1 : slot_q;
    if (reset) begin
      cnt_d  = '0;
      sub_d  = '0;
      slot_d = '0;
    end

    load        = reset || frame_end;
    sh_bright_d = load ? brightness : sh_bright_q;
    sh_en_d     = load ? digit_en   : sh_en_q;
    sh_lzb_d    = load ? lzb_en     : sh_lzb_q;
    sh_dig_d    = load ? digits     : sh_dig_q;

    // zero_from[i]: nibbles i..7 of the shadowed value are all zero
    zero_from    = '0;
    zero_from[7] = (sh_dig_d[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (sh_dig_d[4*i +: 4] == 4'h0);
    end
    blank = sh_lzb_d ? {zero_from[7:1], 1'b0} : 8'h00;

    // outputs are computed from next-state so they line up with the counters
    lit = (sub_d != 4'd0) && (sub_d <= sh_bright_d)
       && sh_en_d[slot_d] && !blank[slot_d];

    select_d = slot_d;
    anodes_d = lit ? ~(8'b1 << slot_d) : 8'hFF;
    tick_d   = (slot_d == 3'd7) && (sub_d == 4'hF) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    cnt_q       <= cnt_d;
    sub_q       <= sub_d;
    slot_q      <= slot_d;
    sh_bright_q <= sh_bright_d;
    sh_en_q     <= sh_en_d;
    sh_lzb_q    <= sh_lzb_d;
    sh_dig_q    <= sh_dig_d;
    select_q    <= select_d;
    anodes_q    <= anodes_d;
    tick_q      <= tick_d;
  end

  assign select     = select_q;
  assign anodes     = anodes_q;
  assign frame_tick = tick_q;

endmodule
